// File: rtl/experiment_scheduler.sv
// Shot sequencer in front of the experiment scenario FSM: applies one timing profile
// per shot, spaces shots by an interval, and supervises each shot with watchdog/abort.
module experiment_scheduler #(
    parameter int NUM_PROFILES = 4,
    parameter int CNT_W        = 32,
    localparam int PW          = $clog2(NUM_PROFILES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PW+1:0]    cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic             run_req,
    input  logic             abort,
    input  logic [15:0]      shot_total,
    input  logic [CNT_W-1:0] interval,
    input  logic [CNT_W-1:0] watchdog,
    input  logic [7:0]       exp_state,
    output logic             exp_start,
    output logic             exp_reset,
    output logic [CNT_W-1:0] par_fg_open_delay,
    output logic [CNT_W-1:0] par_detonate_len,
    output logic [CNT_W-1:0] par_trigger_len,
    output logic [CNT_W-1:0] par_detector_timeout,
    output logic [PW-1:0]    profile_idx,
    output logic [15:0]      shots_done,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);
    localparam int NREG = NUM_PROFILES * 4;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_FIN, S_RELEASE,
        S_WAIT_IDLE, S_INTERVAL, S_ABORT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] prof_q [NREG];
    logic [CNT_W-1:0] prof_d [NREG];

    logic [15:0]      shot_total_q, shot_total_d;
    logic [CNT_W-1:0] iv_lat_q, iv_lat_d;
    logic [CNT_W-1:0] wd_lat_q, wd_lat_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [CNT_W-1:0] iv_cnt_q, iv_cnt_d;
    logic             abort_ph_q, abort_ph_d;
    logic             exp_start_q, exp_start_d;
    logic             exp_reset_q, exp_reset_d;
    logic [CNT_W-1:0] par_fg_q, par_fg_d;
    logic [CNT_W-1:0] par_det_q, par_det_d;
    logic [CNT_W-1:0] par_trg_q, par_trg_d;
    logic [CNT_W-1:0] par_tmo_q, par_tmo_d;
    logic [PW-1:0]    profile_idx_q, profile_idx_d;
    logic [15:0]      shots_done_q, shots_done_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;

    logic [CNT_W:0] wd_cnt_inc;
    logic [CNT_W:0] iv_cnt_inc;
    logic [16:0]    shots_inc;
    logic           wd_active, wd_expire, abort_hit, iv_done, last_shot;
    logic [PW-1:0]  shot_slot;

    assign wd_cnt_inc = {1'b0, wd_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign iv_cnt_inc = {1'b0, iv_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign shots_inc  = {1'b0, shots_done_q} + 17'd1;
    assign shot_slot  = shots_done_q[PW-1:0];

    assign wd_active = (state_q == S_WAIT_FIN) || (state_q == S_RELEASE) || (state_q == S_WAIT_IDLE);
    // A zero watchdog disables the timeout entirely.
    assign wd_expire = wd_active && (wd_lat_q != '0) && !(wd_cnt_inc < {1'b0, wd_lat_q});
    assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ABORT);
    assign iv_done   = !(iv_cnt_inc < {1'b0, iv_lat_q});
    assign last_shot = !(shots_inc < {1'b0, shot_total_q});

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (run_req) state_d = (shot_total == 16'd0) ? S_DONE : S_LOAD;
            S_LOAD:      state_d = S_START;
            S_START:     state_d = S_WAIT_FIN;
            S_WAIT_FIN:  if (exp_state == 8'd8) state_d = S_RELEASE;
            S_RELEASE:   state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (exp_state == 8'd0) state_d = last_shot ? S_DONE : S_INTERVAL;
            S_INTERVAL:  if (iv_done) state_d = S_LOAD;
            S_ABORT:     if (abort_ph_q) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (abort_hit || wd_expire) state_d = S_ABORT;
    end

    always_comb begin
        prof_d = prof_q;
        if (cfg_we) prof_d[cfg_addr] = cfg_data;
        shot_total_d  = shot_total_q;
        iv_lat_d      = iv_lat_q;
        wd_lat_d      = wd_lat_q;
        wd_cnt_d      = wd_cnt_q;
        iv_cnt_d      = iv_cnt_q;
        abort_ph_d    = 1'b0;
        exp_start_d   = exp_start_q;
        exp_reset_d   = 1'b0;
        par_fg_d      = par_fg_q;
        par_det_d     = par_det_q;
        par_trg_d     = par_trg_q;
        par_tmo_d     = par_tmo_q;
        profile_idx_d = profile_idx_q;
        shots_done_d  = shots_done_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = error_q;
        err_code_d    = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (run_req) begin
                    shot_total_d = shot_total;
                    // Keep start low for at least two cycles between shots.
                    iv_lat_d     = (interval < CNT_W'(2)) ? CNT_W'(2) : interval;
                    wd_lat_d     = watchdog;
                    shots_done_d = 16'd0;
                    error_d      = 1'b0;
                    err_code_d   = 2'd0;
                    busy_d       = 1'b1;
                end
            end
            S_LOAD: begin
                par_fg_d      = prof_q[{shot_slot, 2'd0}];
                par_det_d     = prof_q[{shot_slot, 2'd1}];
                par_trg_d     = prof_q[{shot_slot, 2'd2}];
                par_tmo_d     = prof_q[{shot_slot, 2'd3}];
                profile_idx_d = shot_slot;
            end
            S_START: begin
                exp_start_d = 1'b1;
                wd_cnt_d    = '0;
            end
            S_WAIT_FIN: wd_cnt_d = wd_cnt_inc[CNT_W-1:0];
            S_RELEASE: begin
                exp_start_d = 1'b0;
                wd_cnt_d    = wd_cnt_inc[CNT_W-1:0];
            end
            S_WAIT_IDLE: begin
                wd_cnt_d = wd_cnt_inc[CNT_W-1:0];
                iv_cnt_d = '0;
                if (exp_state == 8'd0) shots_done_d = shots_inc[15:0];
            end
            S_INTERVAL: iv_cnt_d = iv_cnt_inc[CNT_W-1:0];
            S_ABORT: begin
                exp_start_d = 1'b0;
                exp_reset_d = 1'b1;
                error_d     = 1'b1;
                abort_ph_d  = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
        // Abort wins over a simultaneous watchdog expiry; an aborted shot is not counted.
        if (abort_hit || wd_expire) begin
            err_code_d   = abort_hit ? 2'd2 : 2'd1;
            exp_start_d  = 1'b0;
            shots_done_d = shots_done_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) prof_q[i] <= '0;
            shot_total_q  <= '0;
            iv_lat_q      <= '0;
            wd_lat_q      <= '0;
            wd_cnt_q      <= '0;
            iv_cnt_q      <= '0;
            abort_ph_q    <= 1'b0;
            exp_start_q   <= 1'b0;
            exp_reset_q   <= 1'b0;
            par_fg_q      <= '0;
            par_det_q     <= '0;
            par_trg_q     <= '0;
            par_tmo_q     <= '0;
            profile_idx_q <= '0;
            shots_done_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= 2'd0;
        end else begin
            prof_q        <= prof_d;
            shot_total_q  <= shot_total_d;
            iv_lat_q      <= iv_lat_d;
            wd_lat_q      <= wd_lat_d;
            wd_cnt_q      <= wd_cnt_d;
            iv_cnt_q      <= iv_cnt_d;
            abort_ph_q    <= abort_ph_d;
            exp_start_q   <= exp_start_d;
            exp_reset_q   <= exp_reset_d;
            par_fg_q      <= par_fg_d;
            par_det_q     <= par_det_d;
            par_trg_q     <= par_trg_d;
            par_tmo_q     <= par_tmo_d;
            profile_idx_q <= profile_idx_d;
            shots_done_q  <= shots_done_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign exp_start            = exp_start_q;
    assign exp_reset            = exp_reset_q;
    assign par_fg_open_delay    = par_fg_q;
    assign par_detonate_len     = par_det_q;
    assign par_trigger_len      = par_trg_q;
    assign par_detector_timeout = par_tmo_q;
    assign profile_idx          = profile_idx_q;
    assign shots_done           = shots_done_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;
    assign err_code             = err_code_q;

endmodule

// File: tb/tb_experiment_scheduler.sv
// Bench for experiment_scheduler: scenario FSM model, scoreboard of expected shot
// starts and run completions, and timing checks on the documented latencies.
module tb_experiment_scheduler;
    localparam int NP = 4;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [CW-1:0] cfg_data = '0;
    logic          run_req = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   shot_total = '0;
    logic [CW-1:0] interval = '0;
    logic [CW-1:0] watchdog = '0;
    logic [7:0]    exp_state = '0;
    logic          exp_start, exp_reset, busy, done, error;
    logic [CW-1:0] par_fg, par_det, par_trg, par_tmo;
    logic [1:0]    profile_idx, err_code;
    logic [15:0]   shots_done;

    experiment_scheduler #(.NUM_PROFILES(NP), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .run_req(run_req), .abort(abort), .shot_total(shot_total), .interval(interval),
        .watchdog(watchdog), .exp_state(exp_state), .exp_start(exp_start), .exp_reset(exp_reset),
        .par_fg_open_delay(par_fg), .par_detonate_len(par_det), .par_trigger_len(par_trg),
        .par_detector_timeout(par_tmo), .profile_idx(profile_idx), .shots_done(shots_done),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_done;
        logic [1:0]  idx;
        logic [31:0] f0, f1, f2, f3;
        logic [15:0] sd;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tbl [NP*4];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_gap = 5;
    int fin_len = 10;
    bit fsm_stuck = 0;
    int fsm_cnt = 0;
    int start_rise_cyc = 0, rst_rise_cyc = 0, done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_shot(input int k);
        exp_t e;
        int p = k % NP;
        e = '{default: '0};
        e.is_done = 0;
        e.idx = 2'(p);
        e.f0 = tbl[p*4+0]; e.f1 = tbl[p*4+1]; e.f2 = tbl[p*4+2]; e.f3 = tbl[p*4+3];
        sb_q.push_back(e);
    endtask

    task automatic push_done(input int sd, input bit err, input int code);
        exp_t e;
        e = '{default: '0};
        e.is_done = 1;
        e.sd = 16'(sd); e.err = err; e.code = 2'(code);
        sb_q.push_back(e);
    endtask

    // Scenario FSM model: rises to a busy state on start, reports 8 after fin_len
    // cycles, returns to 0 once start drops; exp_reset/reset force it to 0.
    always @(posedge clock) begin
        #1;
        if (reset || exp_reset) begin
            exp_state = 8'd0;
            fsm_cnt = 0;
        end else if (exp_state == 8'd0) begin
            if (exp_start) begin
                exp_state = fsm_stuck ? 8'd3 : 8'd1;
                fsm_cnt = 0;
            end
        end else if (exp_state == 8'd8) begin
            if (!exp_start) exp_state = 8'd0;
        end else if (!fsm_stuck) begin
            fsm_cnt++;
            if (fsm_cnt >= fin_len) exp_state = 8'd8;
        end
    end

    always @(posedge clock) cyc++;

    logic prev_start = 1'b0, prev_rst = 1'b0;
    int   low_cnt = 0, rst_len = 0;
    bit   have_fall = 0;

    always @(negedge clock) begin
        exp_t e;
        if (exp_start && !prev_start) begin
            start_rise_cyc = cyc;
            if (have_fall) chk("shot_gap", 64'(low_cnt), 64'(run_gap));
            have_fall = 0;
            chk("start_expected", 64'((sb_q.size() != 0) && !sb_q[0].is_done), 64'd1);
            if (sb_q.size() != 0 && !sb_q[0].is_done) begin
                e = sb_q.pop_front();
                chk("profile_idx", 64'(profile_idx), 64'(e.idx));
                chk("par_fg_open_delay", 64'(par_fg), 64'(e.f0));
                chk("par_detonate_len", 64'(par_det), 64'(e.f1));
                chk("par_trigger_len", 64'(par_trg), 64'(e.f2));
                chk("par_detector_timeout", 64'(par_tmo), 64'(e.f3));
            end
        end
        if (!exp_start && prev_start) begin
            have_fall = 1;
            low_cnt = 1;
        end else if (!exp_start && have_fall) begin
            low_cnt++;
        end
        if (done) begin
            done_cyc = cyc;
            chk("done_expected", 64'((sb_q.size() != 0) && sb_q[0].is_done), 64'd1);
            if (sb_q.size() != 0 && sb_q[0].is_done) begin
                e = sb_q.pop_front();
                chk("shots_done", 64'(shots_done), 64'(e.sd));
                chk("error", 64'(error), 64'(e.err));
                chk("err_code", 64'(err_code), 64'(e.code));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
        if (exp_reset) begin
            if (!prev_rst) rst_rise_cyc = cyc;
            rst_len++;
        end else if (prev_rst) begin
            chk("exp_reset_len", 64'(rst_len), 64'd2);
            rst_len = 0;
        end
        if (!busy) have_fall = 0;
        prev_start = exp_start;
        prev_rst = exp_reset;
    end

    task automatic write_cfg(input int p, input int f, input logic [31:0] v);
        @(negedge clock);
        cfg_we = 1'b1; cfg_addr = 4'(p*4 + f); cfg_data = v;
        @(negedge clock);
        cfg_we = 1'b0;
        tbl[p*4+f] = v;
    endtask

    task automatic start_run(input int st, input int iv, input int wd, input bit lat);
        @(negedge clock);
        shot_total = 16'(st); interval = iv; watchdog = wd; run_req = 1'b1;
        run_gap = ((iv < 2) ? 2 : iv) + 3;
        @(negedge clock);
        run_req = 1'b0;
        if (lat) begin
            chk("busy_latency", 64'(busy), 64'd1);
            @(negedge clock);
            chk("par_fg_latency", 64'(par_fg), 64'(tbl[0]));
            chk("par_tmo_latency", 64'(par_tmo), 64'(tbl[3]));
            chk("start_early", 64'(exp_start), 64'd0);
            @(negedge clock);
            chk("start_latency", 64'(exp_start), 64'd1);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < budget);
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!exp_start && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("start_seen", 64'(exp_start), 64'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_exp_start", 64'(exp_start), 64'd0);
        chk("rst_exp_reset", 64'(exp_reset), 64'd0);
        chk("rst_par", 64'(par_fg | par_det | par_trg | par_tmo), 64'd0);
        chk("rst_profile_idx", 64'(profile_idx), 64'd0);
        chk("rst_shots_done", 64'(shots_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int st, iv, wd, n;
        for (int i = 0; i < NP*4; i++) tbl[i] = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs();
        reset = 1'b0;

        // Four distinct profiles, 3 shots, interval 10, watchdog 1000.
        for (int p = 0; p < NP; p++)
            for (int f = 0; f < 4; f++) write_cfg(p, f, $urandom);
        fin_len = 50; fsm_stuck = 0;
        for (int k = 0; k < 3; k++) push_shot(k);
        push_done(3, 0, 0);
        start_run(3, 10, 1000, 1);
        wait_done(2000);

        // Randomized normal runs, table partly reprogrammed between runs.
        for (int r = 0; r < 5; r++) begin
            write_cfg($urandom_range(0, NP-1), $urandom_range(0, 3), $urandom);
            st = $urandom_range(1, 6);
            iv = $urandom_range(0, 12);
            wd = ($urandom_range(0, 1) == 1) ? 0 : 400;
            fin_len = $urandom_range(2, 20);
            for (int k = 0; k < st; k++) push_shot(k);
            push_done(st, 0, 0);
            start_run(st, iv, wd, 0);
            wait_done(2000);
        end

        // Zero-shot run.
        push_done(0, 0, 0);
        @(negedge clock);
        shot_total = 16'd0; run_req = 1'b1;
        @(negedge clock);
        run_req = 1'b0;
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_done_early", 64'(done), 64'd0);
        @(negedge clock);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy_end", 64'(busy), 64'd0);
        @(negedge clock);
        chk("zero_done_pulse", 64'(done), 64'd0);

        // Watchdog expiry with a stuck scenario FSM.
        fsm_stuck = 1;
        push_shot(0);
        push_done(0, 1, 1);
        start_run(2, 5, 100, 0);
        wait_done(500);
        @(negedge clock);
        chk("wd_reset_delay", 64'(rst_rise_cyc - start_rise_cyc), 64'd101);
        chk("wd_done_delay", 64'(done_cyc - rst_rise_cyc), 64'd2);
        fsm_stuck = 0;

        // Abort during the interval after the first of five shots.
        fin_len = 10;
        push_shot(0);
        push_done(1, 1, 2);
        start_run(5, 20, 1000, 0);
        n = 0;
        while (shots_done != 16'd1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("abort_reach_interval", 64'(shots_done), 64'd1);
        repeat (3) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        wait_done(50);

        // interval=0, profile 1 rewritten while shot 0 runs.
        fin_len = 15;
        push_shot(0);
        start_run(2, 0, 1000, 0);
        wait_start(20);
        for (int f = 0; f < 4; f++) write_cfg(1, f, $urandom);
        push_shot(1);
        push_done(2, 0, 0);
        wait_done(500);

        // Reset in WAIT_FIN, then a normal run.
        fin_len = 30;
        push_shot(0);
        start_run(1, 4, 1000, 0);
        wait_start(20);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs();
        reset = 1'b0;
        for (int i = 0; i < NP*4; i++) tbl[i] = '0;
        chk("sb_after_reset", 64'(sb_q.size()), 64'd0);
        push_shot(0);
        push_done(1, 0, 0);
        start_run(1, 4, 1000, 1);
        wait_done(500);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/experiment_scheduler.md
# experiment_scheduler

Shot sequencer that sits in front of the experiment scenario FSM. It holds a small table of timing profiles, applies one profile per shot, and generates the FSM's `start` level. It runs a programmed number of shots separated by an inter-shot interval. It also supervises each shot with a watchdog and can force the scenario FSM back to IDLE through a dedicated reset output.

## Interface
Parameters:
- NUM_PROFILES, 4, number of profile slots (power of 2, ≥2); PW = $clog2(NUM_PROFILES)
- CNT_W, 32, width of all timing fields and counters

Ports (clock and reset first):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock domain
- cfg_we  in  1  profile table write strobe
- cfg_addr  in  PW+2  {profile, field}; field 0 FG_OPEN_DELAY, 1 DETONATE_LEN, 2 TRIGGER_LEN, 3 DETECTOR_READY_TIMEOUT
- cfg_data  in  CNT_W  write data
- run_req  in  1  start a run (level sampled in IDLE only)
- abort  in  1  abort current run
- shot_total  in  16  shots per run, sampled on run acceptance
- interval  in  CNT_W  idle cycles between shots, sampled on run acceptance
- watchdog  in  CNT_W  max cycles per shot, sampled on run acceptance
- exp_state  in  8  scenario state from FSM; 0 = IDLE, 8 = DETECTOR_FINISHED
- exp_start  out  1  start level to scenario FSM
- exp_reset  out  1  synchronous reset to scenario FSM
- par_fg_open_delay, par_detonate_len, par_trigger_len, par_detector_timeout  out  CNT_W each  active profile fields
- profile_idx  out  PW  profile of current/last shot
- shots_done  out  16  completed shots in current run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- error  out  1  sticky error, cleared on next accepted run
- err_code  out  2  0 none, 1 watchdog, 2 abort

## Operation
- Profile table: NUM_PROFILES×4 registers, written on cfg_we at any time. It is reset to 0. Writes during a run take effect at the next LOAD.
- Shot k (0-based) uses profile k mod NUM_PROFILES.
- States: IDLE, LOAD, START, WAIT_FIN, RELEASE, WAIT_IDLE, INTERVAL, ABORT, DONE.
- IDLE: when run_req=1, latch shot_total, interval and watchdog, then clear shots_done, error and err_code. busy rises. If shot_total=0, go to DONE; else go to LOAD. run_req is ignored outside IDLE.
- LOAD: copy profile to par_* and set profile_idx, then go to START.
- START: exp_start<=1, clear watchdog counter, then go to WAIT_FIN.
- WAIT_FIN: wait for exp_state==8, then go to RELEASE.
- RELEASE: exp_start<=0, then go to WAIT_IDLE.
- WAIT_IDLE: wait for exp_state==0. Then increment shots_done. If shots_done+1==shot_total, go to DONE; else go to INTERVAL.
- INTERVAL: count max(interval,2) cycles, then go to LOAD. The minimum guarantees the FSM sees start low ≥2 cycles before the next rising edge.
- Watchdog: the counter increments in WAIT_FIN, RELEASE and WAIT_IDLE. Reaching the latched watchdog value goes to ABORT with err_code=1. watchdog=0 disables the timeout.
- abort=1 in any non-IDLE, non-DONE state goes to ABORT with err_code=2. If abort and the watchdog expire in the same cycle, err_code=2. abort in IDLE has no effect.
- ABORT: exp_start<=0, exp_reset=1 for exactly 2 cycles, error<=1, then go to DONE. shots_done is not incremented.
- DONE: done=1 for one cycle, busy<=0, then go to IDLE.
- Arithmetic is unsigned. Counters compare with `<` against latched values, with no wrap. shots_done saturates only via shot_total.

## Timing
- All outputs are registered.
- Reset values: exp_start 0, exp_reset 0, par_* 0, profile_idx 0, shots_done 0, busy 0, done 0, error 0, err_code 0. State is IDLE.
- Reset asserted mid-run returns the block to IDLE next cycle. exp_reset is not pulsed; the system reset also resets the FSM.
- run_req high at edge n: busy=1 at n+1, par_* valid at n+2, exp_start=1 at n+3. Parameters are stable ≥1 cycle before the start edge.
- exp_state==8 seen at edge m gives exp_start=0 at m+2.
- Final exp_state==0 at edge p gives done=1 and busy=0 at p+2.
- Watchdog expiry at edge w gives exp_reset high during w+2 and w+3, and done at w+4.

## Test plan
- Program 4 distinct profiles, then run shot_total=3, interval=10, watchdog=1000, with the FSM model finishing in 50 cycles. Expect 3 exp_start pulses using profiles 0,1,2 with matching par_*, and ≥10 low cycles between pulses. Expect shots_done=3, one done pulse, and error=0.
- shot_total=0: expect done 2 cycles after run_req, and exp_start never rises.
- FSM model stuck in a non-8 state with watchdog=100: expect exp_reset high for 2 cycles ~102 cycles after start, then error=1, err_code=1, shots_done=0, and done.
- abort raised during the INTERVAL of shot 2 of 5: expect err_code=2, shots_done=1, and no further exp_start.
- interval=0 with 2 shots: expect exp_start low for exactly 2 cycles plus the WAIT_IDLE/LOAD overhead between shots. Rewriting profile 1 during shot 0 must be reflected in shot 1.
- Reset asserted while in WAIT_FIN: expect all outputs at reset values next cycle. A subsequent run_req must be accepted normally.
